sprite_blitter: RTL and testbench

Draw engine for the Chip-8 framebuffer. It executes DXYN sprite draws (XOR with collision detect) and 00E0 screen clears against the 512×16-bit framebuffer RAM. The framebuffer's second port is scanned by the display stage through `fbAddr`/`fbData`. The blitter is the only writer of that RAM, and its word/bit layout must match the display scan exactly.

---
 rtl/chip8_fb_pkg.sv | 12 +
 rtl/sprite_align.sv | 20 ++
 rtl/sprite_blitter.sv | 110 +++++++++++
 tb/tb_sprite_blitter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/chip8_fb_pkg.sv
// chip8_fb_pkg: framebuffer geometry shared with the display scan, plus blitter state encodings
package chip8_fb_pkg;
  localparam int FB_AW = 9;
  localparam int FB_DW = 16;
  localparam int LORES_WPR = 4;
  localparam int HIRES_WPR = 8;
  localparam int LORES_W = 64;
  localparam int LORES_H = 32;
  localparam int HIRES_W = 128;
  localparam int HIRES_H = 64;
  typedef enum logic [3:0] {IDLE, FETCH, RD0, WR0, RD1, WR1, NEXT, DONE, CLR} blitState_t;
endpackage

// File: rtl/sprite_align.sv
// sprite_align: shifts a sprite byte onto the 16-bit word grid and XORs it into one framebuffer word
module sprite_align
  import chip8_fb_pkg::*;
(
  input  logic [7:0]       sprByte,
  input  logic [3:0]       shift,
  input  logic             right,
  input  logic [FB_DW-1:0] oldWord,
  output logic [FB_DW-1:0] newWord,
  output logic             hit
);
  logic [23:0]      aligned;
  logic [FB_DW-1:0] pattern;
  always_comb begin
    aligned = {sprByte, 16'h0} >> shift;
    pattern = right ? {aligned[7:0], 8'h0} : aligned[23:8];
    newWord = oldWord ^ pattern;
    hit = |(oldWord & pattern);
  end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: Chip-8 DXYN/00E0 draw engine; define SPRITE_WRAP_EN for SCHIP edge wrap instead of clipping
module sprite_blitter
  import chip8_fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             hires,
  input  logic             start,
  input  logic             clear,
  input  logic [7:0]       sprX,
  input  logic [6:0]       sprY,
  input  logic [3:0]       sprRows,
  input  logic [11:0]      sprBase,
  output logic [11:0]      memAddr,
  input  logic [7:0]       memData,
  output logic [FB_AW-1:0] fbAddr,
  input  logic [FB_DW-1:0] fbRdData,
  output logic [FB_DW-1:0] fbWrData,
  output logic             fbWe,
  output logic             busy,
  output logic             done,
  output logic             collision
);
  blitState_t       state;
  logic [6:0]       x0, rowSum;
  logic [5:0]       y0, row;
  logic [3:0]       rows, r;
  logic [11:0]      base;
  logic [7:0]       spr;
  logic [FB_AW-1:0] w0, w1;
  logic [FB_DW-1:0] newWord;
  logic             rowClip, twoWords, hit, unused;
  sprite_align align (.sprByte(spr), .shift(x0[3:0]), .right(state == WR1), .oldWord(fbRdData), .newWord, .hit);
  always_comb begin
    rowSum = {1'b0, y0} + {3'b0, r};
    row = hires ? rowSum[5:0] : {1'b0, rowSum[4:0]};
    w0 = hires ? {row, x0[6:4]} : {2'b0, row[4:0], x0[5:4]};
    w1 = hires ? {row, x0[6:4] + 3'd1} : {2'b0, row[4:0], x0[5:4] + 2'd1};
`ifdef SPRITE_WRAP_EN
    rowClip = 1'b0;
    twoWords = x0[3:0] > 4'd8;
`else
    rowClip = rowSum + 7'd1 >= (hires ? 7'(HIRES_H) : 7'(LORES_H));
    twoWords = x0[3:0] > 4'd8 && !(hires ? &x0[6:4] : &x0[5:4]);
`endif
    fbWe = state == WR0 || state == WR1 || state == CLR;
    fbWrData = (state == WR0 || state == WR1) ? newWord : '0;
    busy = state != IDLE;
    done = state == DONE;
    unused = ^{sprX[7], sprY[6], rowSum[6]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      memAddr <= '0;
      fbAddr <= '0;
      collision <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      rows <= '0;
      r <= '0;
      base <= '0;
      spr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x0 <= hires ? sprX[6:0] : {1'b0, sprX[5:0]};
          y0 <= hires ? sprY[5:0] : {1'b0, sprY[4:0]};
          rows <= sprRows;
          base <= sprBase;
          memAddr <= sprBase;
          r <= '0;
          fbAddr <= '0;
          if (!clear) collision <= 1'b0;
          state <= clear ? CLR : sprRows == 4'd0 ? NEXT : FETCH;
        end
        FETCH: begin
          fbAddr <= w0;
          state <= RD0;
        end
        RD0: begin
          spr <= memData;
          state <= WR0;
        end
        WR0: begin
          collision <= collision | hit;
          if (twoWords) fbAddr <= w1;
          state <= twoWords ? RD1 : NEXT;
        end
        RD1: state <= WR1;
        WR1: begin
          collision <= collision | hit;
          state <= NEXT;
        end
        NEXT: if (rows == 4'd0 || r + 4'd1 == rows || rowClip) state <= DONE;
        else begin
          r <= r + 4'd1;
          memAddr <= base + {8'h0, r + 4'd1};
          state <= FETCH;
        end
        CLR: begin
          fbAddr <= fbAddr + 9'd1;
          if (&fbAddr) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench against a pixel-level framebuffer model
`timescale 1ns/1ps
module tb_sprite_blitter;
  logic clk = 0, reset = 1, hires = 0, start = 0, clear = 0;
  logic [7:0] sprX = 0;
  logic [6:0] sprY = 0;
  logic [3:0] sprRows = 0;
  logic [11:0] sprBase = 0;
  logic [11:0] memAddr;
  logic [7:0] memData;
  logic [8:0] fbAddr;
  logic [15:0] fbRdData, fbWrData;
  logic fbWe, busy, done, collision;
  logic [15:0] fb [512];
  logic [15:0] mfb [512];
  logic [7:0] rom [4096];
  bit mColl = 0;
  int tests = 0, failed = 0, wrCount = 0;
  typedef struct { int lat; bit coll; int writes; } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .hires(hires), .start(start), .clear(clear),
    .sprX(sprX), .sprY(sprY), .sprRows(sprRows), .sprBase(sprBase),
    .memAddr(memAddr), .memData(memData), .fbAddr(fbAddr), .fbRdData(fbRdData),
    .fbWrData(fbWrData), .fbWe(fbWe), .busy(busy), .done(done), .collision(collision)
  );

  always @(posedge clk) begin
    if (fbWe) fb[fbAddr] <= fbWrData;
    if (fbWe) wrCount <= wrCount + 1;
    fbRdData <= fb[fbAddr];
    memData <= rom[memAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit clr, input int x, input int y, input int n, input int base, output exp_t e);
    int w, h, wpr, x0, y0, yy, xx, wa, wb, a, k;
    logic [7:0] b;
    w = hires ? 128 : 64;
    h = hires ? 64 : 32;
    wpr = hires ? 8 : 4;
    e.lat = 1;
    e.writes = 0;
    if (clr) begin
      for (int i = 0; i < 512; i++) mfb[i] = '0;
      e.lat = 513;
      e.writes = 512;
      e.coll = mColl;
      return;
    end
    x0 = x % w;
    y0 = y % h;
    mColl = 0;
    for (int rr = 0; rr < n; rr++) begin
      yy = y0 + rr;
      if (yy >= h) begin
`ifdef SPRITE_WRAP_EN
        yy -= h;
`else
        break;
`endif
      end
      b = rom[12'(base + rr)];
      wa = -1;
      wb = -1;
      for (int p = 0; p < 8; p++) begin
        xx = x0 + p;
        if (xx >= w) begin
`ifdef SPRITE_WRAP_EN
          xx -= w;
`else
          continue;
`endif
        end
        a = yy * wpr + xx / 16;
        k = 15 - xx % 16;
        if (wa < 0) wa = a;
        else if (a != wa) wb = a;
        if (b[7-p]) begin
          if (mfb[a][k]) mColl = 1;
          mfb[a][k] = ~mfb[a][k];
        end
      end
      e.writes += (wb < 0) ? 1 : 2;
      e.lat += (wb < 0) ? 4 : 6;
    end
    if (n == 0) e.lat = 2;
    e.coll = mColl;
  endtask

  task automatic runCmd(input string tag, input bit clr, input bit hr, input logic [7:0] x,
                        input logic [6:0] y, input logic [3:0] n, input logic [11:0] base, input bit poke);
    exp_t e, got;
    int lat, w0, bad;
    @(negedge clk);
    hires = hr;
    model(clr, int'(x), int'(y), int'(n), int'(base), e);
    sb.push_back(e);
    clear = clr; sprX = x; sprY = y; sprRows = n; sprBase = base; start = 1;
    w0 = wrCount;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 0;
      if (poke && lat == 2) begin clear = 1; start = 1; end
      if (poke && lat == 3) begin clear = 0; start = 0; end
    end while (!done && lat < 2000);
    check({tag, ".queued"}, sb.size(), 1);
    got = sb.pop_front();
    check({tag, ".latency"}, lat, got.lat);
    check({tag, ".collision"}, collision, got.coll);
    check({tag, ".writes"}, wrCount - w0, got.writes);
    bad = 0;
    for (int i = 0; i < 512; i++) if (fb[i] !== mfb[i]) bad++;
    check({tag, ".fbwords"}, bad, 0);
  endtask

  initial begin
    exp_t dummy;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.collision", collision, 0);
    check("rst.fbWe", fbWe, 0);
    check("rst.fbAddr", fbAddr, 0);
    check("rst.fbWrData", fbWrData, 0);
    check("rst.memAddr", memAddr, 0);
    reset = 0;
    runCmd("clr0", 1, 0, 0, 0, 0, 0, 0);
    rom[12'h200] = 8'hF0;
    runCmd("lores", 0, 0, 0, 0, 1, 12'h200, 0);
    check("lores.w0", fb[0], 16'hF000);
    runCmd("clr1", 1, 0, 0, 0, 0, 0, 0);
    rom[12'h300] = 8'hFF;
    runCmd("strad1", 0, 0, 12, 0, 1, 12'h300, 0);
    check("strad1.w0", fb[0], 16'h000F);
    check("strad1.w1", fb[1], 16'hF000);
    runCmd("strad2", 0, 0, 12, 0, 1, 12'h300, 1);
    check("strad2.w0", fb[0], 16'h0000);
    check("strad2.w1", fb[1], 16'h0000);
    check("strad2.vf", collision, 1);
    runCmd("n0", 0, 0, 5, 5, 0, 12'h300, 0);
    check("n0.vf", collision, 0);
    runCmd("clr2", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rom[12'h400 + i] = 8'hFF;
    runCmd("edge", 0, 0, 60, 30, 4, 12'h400, 0);
    check("edge.w123", fb[123], 16'h000F);
    check("edge.w127", fb[127], 16'h000F);
`ifdef SPRITE_WRAP_EN
    check("edge.w120", fb[120], 16'hF000);
    check("edge.w0", fb[0], 16'hF000);
`else
    check("edge.w124", fb[124], 16'h0000);
    check("edge.w0", fb[0], 16'h0000);
`endif
    runCmd("clr3", 1, 0, 0, 0, 0, 0, 0);
    rom[12'h500] = 8'h81;
    runCmd("hires", 0, 1, 130, 65, 1, 12'h500, 0);
    check("hires.w8", fb[8], 16'h2040);
    runCmd("romwrap", 0, 0, 9, 3, 4, 12'hFFE, 0);
    for (int k = 0; k < 10; k++)
      runCmd("rand", 0, 1'($urandom), 8'($urandom), 7'($urandom), 4'($urandom), 12'($urandom), 0);
    runCmd("clrfull", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    hires = 0; clear = 0; sprX = 0; sprY = 2; sprRows = 3; sprBase = 12'h400; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    check("abort.wr0", fbWe, 1);
    reset = 1;
    @(negedge clk);
    check("abort.busy", busy, 0);
    check("abort.fbWe", fbWe, 0);
    check("abort.vf", collision, 0);
    reset = 0;
    model(0, 0, 2, 1, 12'h400, dummy);
    runCmd("post", 0, 0, 20, 2, 2, 12'h400, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
